// File: rtl/sound_rom_arbiter_if.sv
// rtl/sound_rom_arbiter_if.sv - channel request/ack bus and sample ROM port of the sound arbiter
interface sound_rom_arbiter_if #(
  parameter int N_CH = 10
);
  logic [N_CH-1:0]    req;
  logic [24*N_CH-1:0] req_addr;
  logic [N_CH-1:0]    ack;
  logic [7:0]         ack_data;
  logic               ack_timeout;
  logic               busy;
  logic               rom_load;
  logic [23:0]        rom_addr;
  logic [7:0]         rom_data;
  logic               rom_ready;

  modport master (
    input  req, req_addr, rom_data, rom_ready,
    output ack, ack_data, ack_timeout, busy, rom_load, rom_addr
  );

  modport slave (
    output req, req_addr, rom_data, rom_ready,
    input  ack, ack_data, ack_timeout, busy, rom_load, rom_addr
  );
endinterface

// File: rtl/sound_rom_arbiter.sv
// rtl/sound_rom_arbiter.sv - round-robin arbiter sharing the sample ROM port between sound channels
module sound_rom_arbiter #(
  parameter int N_CH    = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  sound_rom_arbiter_if.master  bus
);
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   grant_idx;
  logic            grant_valid;
  logic [7:0]      wait_cnt;
  logic            wait_expired;
  logic [23:0]     rom_addr_q;
  logic [N_CH-1:0] ack_q;
  logic [7:0]      ack_data_q;
  logic            ack_timeout_q;
  logic            rom_load_c;
  logic            busy_c;

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_CH) s = s - N_CH;
    return PW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus.req[rr_index(ptr, i)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_index(ptr, i);
      end
    end
  end

  // The counter is registered, so the last WAIT cycle is the one where it still reads TIMEOUT-1.
  assign wait_expired = (wait_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rom_load_c = 1'b0;
    busy_c     = 1'b1;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (grant_valid) state_nxt = LOAD;
      end
      LOAD: begin
        rom_load_c = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (bus.rom_ready || wait_expired) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      winner        <= '0;
      wait_cnt      <= 8'h00;
      rom_addr_q    <= 24'h0;
      ack_q         <= '0;
      ack_data_q    <= 8'h00;
      ack_timeout_q <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            winner     <= grant_idx;
            rom_addr_q <= bus.req_addr[24*int'(grant_idx) +: 24];
          end
        end
        LOAD: wait_cnt <= 8'h00;
        WAIT: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (bus.rom_ready) begin
            ack_q         <= N_CH'(1) << winner;
            ack_data_q    <= bus.rom_data;
            ack_timeout_q <= 1'b0;
          end else if (wait_expired) begin
            ack_q         <= N_CH'(1) << winner;
            ack_data_q    <= 8'h00;
            ack_timeout_q <= 1'b1;
          end
        end
        DONE: begin
          if (winner == PW'(N_CH - 1)) ptr <= '0;
          else                         ptr <= winner + PW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.ack         = ack_q;
  assign bus.ack_data    = ack_data_q;
  assign bus.ack_timeout = ack_timeout_q;
  assign bus.busy        = busy_c;
  assign bus.rom_load    = rom_load_c;
  assign bus.rom_addr    = rom_addr_q;
endmodule

// File: tb/tb_sound_rom_arbiter.sv
// tb/tb_sound_rom_arbiter.sv - directed self-checking bench for sound_rom_arbiter
module tb_sound_rom_arbiter;
  localparam int N_CH    = 10;
  localparam int TIMEOUT = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sound_rom_arbiter_if #(.N_CH(N_CH)) bus();

  sound_rom_arbiter #(.N_CH(N_CH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int          rel;
  int          load_age;
  int          ready_delay;
  int          ready_pulse_rel;
  logic        use_fixed;
  logic [7:0]  fixed_byte;
  logic        auto_drop;
  int          load_count;
  logic [23:0] load_addr;
  int          load_rel;

  logic [N_CH-1:0] ack_val_q[$];
  logic [7:0]      ack_data_q[$];
  logic            ack_to_q[$];
  int              ack_rel_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  // One clock; ROM model and ack logging run #1 after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    rel++;
    if (bus.rom_load) begin
      load_count++;
      load_addr = bus.rom_addr;
      load_rel  = rel;
      load_age  = 0;
    end else if (load_age >= 0) begin
      load_age++;
    end
    if (bus.ack != '0) begin
      ack_val_q.push_back(bus.ack);
      ack_data_q.push_back(bus.ack_data);
      ack_to_q.push_back(bus.ack_timeout);
      ack_rel_q.push_back(rel);
      if (auto_drop) bus.req = bus.req & ~bus.ack;
    end
    bus.rom_ready = (ready_delay >= 0 && load_age == ready_delay) || (rel == ready_pulse_rel);
    bus.rom_data  = use_fixed ? fixed_byte : (bus.rom_addr[7:0] ^ 8'h5A);
  endtask

  task automatic begin_test();
    rel        = 0;
    load_age   = -1;
    load_count = 0;
    load_rel   = -1;
    ack_val_q.delete();
    ack_data_q.delete();
    ack_to_q.delete();
    ack_rel_q.delete();
  endtask

  task automatic run_acks(input int n, input int budget);
    int k;
    k = 0;
    while (ack_val_q.size() < n && k < budget) begin
      step();
      k++;
    end
    if (ack_val_q.size() < n) begin
      check("ack_wait", 32'(ack_val_q.size()), 32'(n));
      while (ack_val_q.size() < n) begin
        ack_val_q.push_back('0);
        ack_data_q.push_back(8'h00);
        ack_to_q.push_back(1'b0);
        ack_rel_q.push_back(-1);
      end
    end
  endtask

  task automatic set_default_addrs();
    for (int i = 0; i < N_CH; i++)
      bus.req_addr[24*i +: 24] = {8'hC0 + 8'(i), 8'h00, 8'h10 + 8'(i)};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_d;
    bus.req         = '0;
    bus.rom_ready   = 1'b0;
    bus.rom_data    = 8'h00;
    set_default_addrs();
    ready_delay     = -1;
    ready_pulse_rel = -100;
    use_fixed       = 1'b0;
    fixed_byte      = 8'h00;
    auto_drop       = 1'b1;
    begin_test();

    rst = 1'b1;
    step();
    step();
    check("rst_ack",         32'(bus.ack),         32'h0);
    check("rst_ack_data",    32'(bus.ack_data),    32'h0);
    check("rst_ack_timeout", 32'(bus.ack_timeout), 32'h0);
    check("rst_busy",        32'(bus.busy),        32'h0);
    check("rst_rom_load",    32'(bus.rom_load),    32'h0);
    check("rst_rom_addr",    32'(bus.rom_addr),    32'h0);
    check("rst_ptr",         32'(dut.ptr),         32'h0);
    rst = 1'b0;
    step();

    // Single request on channel 2, ready three cycles after the load.
    begin_test();
    use_fixed   = 1'b1;
    fixed_byte  = 8'hA5;
    ready_delay = 3;
    bus.req_addr[24*2 +: 24] = 24'h012345;
    bus.req = 10'b0000000100;
    run_acks(1, 20);
    check("single_load_count", 32'(load_count),    32'd1);
    check("single_load_cycle", 32'(load_rel),      32'd1);
    check("single_rom_addr",   32'(load_addr),     32'h012345);
    check("single_ack",        32'(ack_val_q[0]),  32'h004);
    check("single_ack_data",   32'(ack_data_q[0]), 32'hA5);
    check("single_ack_to",     32'(ack_to_q[0]),   32'h0);
    check("single_ack_cycle",  32'(ack_rel_q[0]),  32'd5);
    step();
    check("single_ack_pulse",  32'(bus.ack),       32'h0);
    check("single_ptr",        32'(dut.ptr),       32'd3);
    set_default_addrs();

    // Fairness with every channel held high from ptr 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    begin_test();
    use_fixed   = 1'b0;
    ready_delay = 1;
    auto_drop   = 1'b0;
    bus.req     = '1;
    run_acks(11, 80);
    bus.req     = '0;
    auto_drop   = 1'b1;
    check("fair_first_cycle", 32'(ack_rel_q[0]), 32'd3);
    for (int k = 0; k < 11; k++) begin
      exp_d = (8'h10 + 8'(k % 10)) ^ 8'h5A;
      check($sformatf("fair_ack_%0d", k),  32'(ack_val_q[k]),  32'(1) << (k % 10));
      check($sformatf("fair_data_%0d", k), 32'(ack_data_q[k]), 32'(exp_d));
      if (k > 0)
        check($sformatf("fair_gap_%0d", k), 32'(ack_rel_q[k] - ack_rel_q[k-1]), 32'd4);
    end
    step();
    step();
    check("fair_ptr", 32'(dut.ptr), 32'd1);

    // Move ptr to 8, then requests on 2 and 9 must wrap: 9 first, then 2.
    begin_test();
    bus.req = 10'b0010000000;
    run_acks(1, 20);
    check("wrap_prep_ack", 32'(ack_val_q[0]), 32'h080);
    step();
    check("wrap_prep_ptr", 32'(dut.ptr), 32'd8);
    begin_test();
    bus.req = 10'b1000000100;
    run_acks(2, 30);
    check("wrap_first",  32'(ack_val_q[0]), 32'h200);
    check("wrap_second", 32'(ack_val_q[1]), 32'h004);
    step();
    check("wrap_ptr", 32'(dut.ptr), 32'd3);

    // Timeout: no ready, ack at cycle 2+TIMEOUT; a late ready at cycle 9 is ignored.
    begin_test();
    use_fixed       = 1'b1;
    fixed_byte      = 8'hEE;
    ready_delay     = -1;
    ready_pulse_rel = 9;
    bus.req         = 10'b0000100000;
    run_acks(1, 20);
    check("to_ack",       32'(ack_val_q[0]),  32'h020);
    check("to_ack_cycle", 32'(ack_rel_q[0]),  32'd7);
    check("to_ack_data",  32'(ack_data_q[0]), 32'h00);
    check("to_ack_flag",  32'(ack_to_q[0]),   32'h1);
    while (rel < 12) step();
    check("to_late_acks",  32'(ack_val_q.size()), 32'd1);
    check("to_late_loads", 32'(load_count),       32'd1);
    check("to_late_busy",  32'(bus.busy),         32'h0);
    ready_pulse_rel = -100;

    // Ready arrives in the very cycle the counter hits TIMEOUT: data wins.
    begin_test();
    fixed_byte  = 8'h3C;
    ready_delay = 5;
    bus.req     = 10'b0001000000;
    run_acks(1, 20);
    check("coll_ack_cycle", 32'(ack_rel_q[0]),  32'd7);
    check("coll_ack_data",  32'(ack_data_q[0]), 32'h3C);
    check("coll_ack_flag",  32'(ack_to_q[0]),   32'h0);
    step();

    // Reset during WAIT with the request still held.
    begin_test();
    ready_delay = -1;
    bus.req     = 10'b0000010000;
    step();
    step();
    step();
    check("mrst_busy_before", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    load_age = -1;
    check("mrst_busy",        32'(bus.busy),        32'h0);
    check("mrst_ack",         32'(bus.ack),         32'h0);
    check("mrst_rom_load",    32'(bus.rom_load),    32'h0);
    check("mrst_rom_addr",    32'(bus.rom_addr),    32'h0);
    check("mrst_ack_data",    32'(bus.ack_data),    32'h0);
    check("mrst_ack_timeout", 32'(bus.ack_timeout), 32'h0);
    check("mrst_ptr",         32'(dut.ptr),         32'h0);
    ready_delay = 1;
    run_acks(1, 20);
    check("mrst_load_count", 32'(load_count),   32'd2);
    check("mrst_reload",     32'(load_rel),     32'd5);
    check("mrst_ack",        32'(ack_val_q[0]), 32'h010);
    check("mrst_ack_cycle",  32'(ack_rel_q[0]), 32'd7);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
